// File: rtl/axis_gpio_mux_pkg.sv
// Shared types and constants for the GPIO-controlled AXI-Stream mux.
// Imported by the mux top and its output register.
package axis_gpio_mux_pkg;

    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

endpackage

// File: rtl/axis_gpio_mux_oreg.sv
// Single-entry AXI-Stream output register with ready pass-back.
// Accepts a beat whenever it is empty or being drained this cycle.
module axis_gpio_mux_oreg
    import axis_gpio_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_gpio_mux.sv
// Two-source AXI-Stream mux steered by GPIO enable/drop/sel at packet edges.
// Optional drop counter: define AXIS_GPIO_MUX_DROP_CNT_EN.
module axis_gpio_mux
    import axis_gpio_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  drop,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
`endif
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    state_t                state;
    logic                  sel_q;
    logic                  live;
    logic                  cur_sel;
    logic [DATA_WIDTH-1:0] sd;
    logic [KEEP_WIDTH-1:0] sk;
    logic                  sv;
    logic                  sl;
    logic                  can;
    logic                  go;
    logic                  fire;
    logic                  dropping;

    // In IDLE the live sel pin steers; once a packet starts it is frozen.
    assign cur_sel = (state == ST_IDLE) ? sel : sel_q;
    assign sd = cur_sel ? s1_axis_tdata  : s0_axis_tdata;
    assign sk = cur_sel ? s1_axis_tkeep  : s0_axis_tkeep;
    assign sv = cur_sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign sl = cur_sel ? s1_axis_tlast  : s0_axis_tlast;

    always_comb begin
        go = 1'b0;
        unique case (state)
            ST_IDLE: go = live && enable && can;
            ST_PASS: go = can;
            ST_DROP: go = 1'b1;
            default: go = 1'b0;
        endcase
    end

    assign s0_axis_tready = go && !cur_sel;
    assign s1_axis_tready = go && cur_sel;
    assign fire = go && sv;
    assign dropping = (state == ST_DROP) ||
                      ((state == ST_IDLE) && drop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            sel_q <= 1'b0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (enable) sel_q <= sel;
                    if (fire && !sl)
                        state <= drop ? ST_DROP : ST_PASS;
                end
                ST_PASS, ST_DROP: begin
                    if (fire && sl) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            drop_count <= '0;
        else if (fire && sl && dropping && !(&drop_count))
            drop_count <= drop_count + 1'b1;
    end
`endif

    axis_gpio_mux_oreg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_oreg (
        .clk      (aclk),
        .rst_n    (aresetn),
        .in_data  (sd),
        .in_keep  (sk),
        .in_last  (sl),
        .in_valid (fire && !dropping),
        .in_ready (can),
        .out_data (m_axis_tdata),
        .out_keep (m_axis_tkeep),
        .out_last (m_axis_tlast),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

endmodule

// File: tb/tb_axis_gpio_mux.sv
// Directed bench for axis_gpio_mux: forwarding, steering, drop,
// backpressure, reset and enable gating.
module tb_axis_gpio_mux;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        drop = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] s0_axis_tdata = '0;
    logic [3:0]  s0_axis_tkeep = '0;
    logic        s0_axis_tvalid = 1'b0;
    logic        s0_axis_tlast = 1'b0;
    logic        s0_axis_tready;
    logic [31:0] s1_axis_tdata = '0;
    logic [3:0]  s1_axis_tkeep = '0;
    logic        s1_axis_tvalid = 1'b0;
    logic        s1_axis_tlast = 1'b0;
    logic        s1_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad = 0;
    logic [36:0] outq[$];
    logic watch = 1'b0;
    logic s0_seen = 1'b0;
    logic s1_seen = 1'b0;
    logic mv_seen = 1'b0;

    always #5 aclk = ~aclk;

    axis_gpio_mux dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .drop          (drop),
        .sel           (sel),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tkeep (s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tkeep (s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
        .drop_count    (drop_count),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always @(posedge aclk)
        if (aresetn && m_axis_tvalid && m_axis_tready)
            outq.push_back({m_axis_tkeep, m_axis_tlast, m_axis_tdata});

    always @(negedge aclk)
        if (watch) begin
            if (s0_axis_tready) s0_seen <= 1'b1;
            if (s1_axis_tready) s1_seen <= 1'b1;
            if (m_axis_tvalid)  mv_seen <= 1'b1;
        end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input int src, input logic v, input logic [31:0] d,
                       input logic l);
        if (src == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = d;
            s0_axis_tlast = l;  s0_axis_tkeep = 4'hF;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = d;
            s1_axis_tlast = l;  s1_axis_tkeep = 4'hF;
        end
    endtask

    // Called at a negedge; each beat waits (bounded) for its source tready.
    task automatic send(input int src, input int n, input logic [31:0] base,
                        output int stalls);
        logic rdy;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            int to = 0;
            drv(src, 1'b1, base + i, i == n - 1);
            #1;
            rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
            while (!rdy && to < 40) begin
                @(negedge aclk);
                #1;
                to++;
                stalls++;
                rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
            end
            if (!rdy) chk("send_timeout", 32'(to), 32'd0);
            @(negedge aclk);
        end
        drv(src, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_pkt(input string tag, input int n,
                              input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int to = 0;
            while (outq.size() == 0 && to < 40) begin
                @(negedge aclk);
                to++;
            end
            if (outq.size() == 0) begin
                chk({tag, "_missing"}, 32'd0, 32'd1);
            end else begin
                logic [36:0] e;
                e = outq.pop_front();
                chk({tag, "_data"}, e[31:0], base + i);
                chk({tag, "_last"}, {31'd0, e[32]},
                    {31'd0, i == n - 1});
                chk({tag, "_keep"}, {28'd0, e[36:33]}, 32'hF);
            end
        end
    endtask

    int st;
    logic [31:0] hold;

    initial begin
        #2;
        chk("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_mdata", m_axis_tdata, 32'd0);
        chk("rst_rdy", {30'd0, s0_axis_tready, s1_axis_tready}, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // basic forward from s0
        enable = 1'b1;
        s1_seen = 1'b0; watch = 1'b1;
        send(0, 4, 32'd1, st);
        expect_pkt("fwd", 4, 32'd1);
        watch = 1'b0;
        chk("fwd_s1rdy", {31'd0, s1_seen}, 32'd0);
        chk("fwd_stall", 32'(st), 32'd0);

        // sel flips mid-packet: stays on s0, next packet from s1
        fork
            send(0, 4, 32'h10, st);
            begin
                repeat (2) @(negedge aclk);
                sel = 1'b1;
            end
        join
        expect_pkt("selmid", 4, 32'h10);
        send(1, 2, 32'h100, st);
        expect_pkt("selnext", 2, 32'h100);

        // drop a 3-beat packet on s1
        @(negedge aclk);
        drop = 1'b1;
        mv_seen = 1'b0; watch = 1'b1;
        send(1, 3, 32'h200, st);
        repeat (2) @(negedge aclk);
        watch = 1'b0;
        chk("drop_stall", 32'(st), 32'd0);
        chk("drop_mvalid", {31'd0, mv_seen}, 32'd0);
        chk("drop_q", 32'(outq.size()), 32'd0);
`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
        chk("drop_cnt", {16'd0, drop_count}, 32'd1);
`endif
        drop = 1'b0;
        sel = 1'b0;

        // backpressure: first beat parks in the output register
        m_axis_tready = 1'b0;
        fork
            send(0, 4, 32'h20, st);
            begin
                repeat (2) @(negedge aclk);
                hold = m_axis_tdata;
                chk("bp_hold0", hold, 32'h20);
                for (int k = 0; k < 5; k++) begin
                    @(negedge aclk);
                    chk("bp_stable", m_axis_tdata, hold);
                    chk("bp_vld", {31'd0, m_axis_tvalid}, 32'd1);
                    chk("bp_install", {31'd0, s0_axis_tready}, 32'd0);
                end
                m_axis_tready = 1'b1;
            end
        join
        expect_pkt("bp", 4, 32'h20);
        chk("bp_extra", 32'(outq.size()), 32'd0);

        // async reset during beat 2
        drv(0, 1'b1, 32'h30, 1'b0);
        @(negedge aclk);
        drv(0, 1'b1, 32'h31, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("ar_mdata", m_axis_tdata, 32'd0);
        chk("ar_mlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("ar_rdy", {30'd0, s0_axis_tready, s1_axis_tready}, 32'd0);
        drv(0, 1'b0, '0, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        outq.delete();
        @(negedge aclk);
        send(0, 3, 32'h40, st);
        expect_pkt("ar_next", 3, 32'h40);
`ifdef AXIS_GPIO_MUX_DROP_CNT_EN
        chk("ar_cnt", {16'd0, drop_count}, 32'd0);
`endif

        // enable gating with both sources valid
        enable = 1'b0;
        drv(0, 1'b1, 32'hAA, 1'b1);
        drv(1, 1'b1, 32'h300, 1'b1);
        s0_seen = 1'b0; s1_seen = 1'b0; watch = 1'b1;
        repeat (3) @(negedge aclk);
        chk("en0_s0rdy", {31'd0, s0_seen}, 32'd0);
        chk("en0_s1rdy", {31'd0, s1_seen}, 32'd0);
        chk("en0_q", 32'(outq.size()), 32'd0);
        enable = 1'b1;
        sel = 1'b1;
        send(1, 1, 32'h300, st);
        expect_pkt("en1", 1, 32'h300);
        watch = 1'b0;
        chk("en1_s0rdy", {31'd0, s0_seen}, 32'd0);
        drv(0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge aclk);
        chk("end_q", 32'(outq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
